// File: rtl/box_game_pkg.sv
// box_game_pkg: screen geometry, direction encoding and the per-axis motion update shared by the box game blocks
package box_game_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int HALF_SIZE = 25;

    localparam int X_MIN = HALF_SIZE;
    localparam int X_MAX = SCREEN_W - 1 - HALF_SIZE;
    localparam int Y_MIN = HALF_SIZE;
    localparam int Y_MAX = SCREEN_H - 1 - HALF_SIZE;

    typedef logic signed [1:0] dir_t;

    localparam dir_t DIR_NEG  = 2'sb11;
    localparam dir_t DIR_NONE = 2'sb00;
    localparam dir_t DIR_POS  = 2'sb01;

    typedef struct packed {
        logic [9:0] pos;
        logic [3:0] speed;
        dir_t       dir;
    } axis_t;

    // One frame of motion on one axis: ramp the speed while the direction holds, then move and clamp.
    // The sum is kept in 11-bit signed so a step past either screen end cannot wrap before clamping.
    function automatic axis_t axis_step(input axis_t cur, input dir_t dir, input logic [9:0] lo,
                                        input logic [9:0] hi, input int max_step);
        axis_t nxt;
        logic signed [10:0] sum;
        nxt.dir   = dir;
        nxt.speed = (dir == DIR_NONE) ? 4'd0 :
                    (dir != cur.dir) ? 4'd1 :
                    (int'(cur.speed) >= max_step) ? 4'(max_step) : cur.speed + 4'd1;
        sum       = 11'(int'(cur.pos) + int'(dir) * int'(nxt.speed));
        nxt.pos   = (sum < $signed({1'b0, lo})) ? lo :
                    (sum > $signed({1'b0, hi})) ? hi : 10'(sum);
        return nxt;
    endfunction

endpackage

// File: rtl/box_motion_controller_debouncer.sv
// button_debouncer: two-flop synchroniser followed by a stable-count debouncer for one push-button
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] count;

    // Accept a new level only after the synchronised input has disagreed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync  <= '0;
            count <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                count <= '0;
            end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/box_motion_controller.sv
// box_motion_controller: debounced buttons move the box centre once per frame with speed ramping and screen clamping
module box_motion_controller #(
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int HALF_SIZE       = 25,
    parameter int START_X         = 320,
    parameter int START_Y         = 240,
    parameter int MAX_STEP        = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_25mHz,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       BTNU,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTND,
    output logic [9:0] center_x,
    output logic [8:0] center_y,
    output logic       at_edge
);

    import box_game_pkg::*;

    localparam logic [9:0] X_LO = 10'(HALF_SIZE);
    localparam logic [9:0] X_HI = 10'(SCREEN_W - 1 - HALF_SIZE);
    localparam logic [9:0] Y_LO = 10'(HALF_SIZE);
    localparam logic [9:0] Y_HI = 10'(SCREEN_H - 1 - HALF_SIZE);

    logic  up, left, right, down;
    logic  screen_end_d, tick;
    dir_t  dir_x, dir_y;
    axis_t ax, ay, ax_next, ay_next;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnu (
        .clk(clk_25mHz), .reset(reset), .raw(BTNU), .level(up)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnl (
        .clk(clk_25mHz), .reset(reset), .raw(BTNL), .level(left)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnr (
        .clk(clk_25mHz), .reset(reset), .raw(BTNR), .level(right)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnd (
        .clk(clk_25mHz), .reset(reset), .raw(BTND), .level(down)
    );

    assign tick = screenEnd & ~screen_end_d;

    // Opposing buttons cancel; screen y grows downwards so up is the negative direction
    always_comb begin
        dir_x   = (right & ~left) ? DIR_POS : (left & ~right) ? DIR_NEG : DIR_NONE;
        dir_y   = (down & ~up) ? DIR_POS : (up & ~down) ? DIR_NEG : DIR_NONE;
        ax_next = axis_step(ax, dir_x, X_LO, X_HI, MAX_STEP);
        ay_next = axis_step(ay, dir_y, Y_LO, Y_HI, MAX_STEP);
    end

    // Motion state advances only on the rising edge of screenEnd; screen_end_d resets high so a held pulse is ignored
    always_ff @(posedge clk_25mHz) begin
        if (!reset) begin
            screen_end_d <= 1'b1;
            ax           <= '{pos: 10'(START_X), speed: 4'd0, dir: DIR_NONE};
            ay           <= '{pos: 10'(START_Y), speed: 4'd0, dir: DIR_NONE};
        end else begin
            screen_end_d <= screenEnd;
            if (tick) begin
                ax <= ax_next;
                ay <= ay_next;
            end
        end
    end

    assign center_x = ax.pos;
    assign center_y = 9'(ay.pos);
    assign at_edge  = (ax.pos == X_LO) || (ax.pos == X_HI) || (ay.pos == Y_LO) || (ay.pos == Y_HI);

endmodule

// File: doc/box_motion_controller.md
# box_motion_controller

Upstream stage of the VGA display path. Turns the four raw board push-buttons into the box centre coordinates the VGA controller draws each frame. Buttons are synchronised and debounced. Position is updated once per frame, on the `screenEnd` pulse, with per-axis speed ramping, and is saturated so the 51×51 box never leaves the 640×480 screen.

## Interface
Parameters:
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `HALF_SIZE`, 25: box half-extent; centre is clamped to [HALF_SIZE, dim−1−HALF_SIZE].
- `START_X`, 320: centre x after reset.
- `START_Y`, 240: centre y after reset.
- `MAX_STEP`, 8: maximum displacement per frame, in pixels.
- `DEBOUNCE_CYCLES`, 250000: stable cycles required to accept a button change (10 ms at 25 MHz).

Ports:
- `clk_25mHz`, in, 1: pixel clock; the only clock.
- `reset`, in, 1: synchronous, active-low (0 = reset).
- `screenEnd`, in, 1: frame-boundary pulse from the timing generator, synchronous to `clk_25mHz`.
- `BTNU`, `BTNL`, `BTNR`, `BTND`, in, 1 each: raw asynchronous buttons, active-high.
- `center_x`, out, 10: box centre x.
- `center_y`, out, 9: box centre y.
- `at_edge`, out, 1: high while either coordinate sits at a clamp limit.

## Operation
- **Button path.** Each button goes through a 2-flop synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the current level before then clears the counter.
- **Frame tick.** `tick = screenEnd & ~screenEnd_d`. The `screenEnd_d` flop resets to 1, so a `screenEnd` already high at reset release produces no tick.
- **Direction per axis** (signed −1/0/+1):
  - x: +1 if right only, −1 if left only.
  - y: −1 if up only, +1 if down only.
  - Both or neither pressed gives 0.
- **Speed per axis** (0..MAX_STEP), evaluated on tick:
  - dir = 0: speed ← 0.
  - dir ≠ 0 and equal to last tick's dir: speed ← min(speed+1, MAX_STEP).
  - dir ≠ 0 and different from last tick's dir (including from 0): speed ← 1.
  - Displacement = dir × new speed.
- **Clamp.**
  - pos ← clamp(pos + displacement, HALF_SIZE, dim−1−HALF_SIZE). Defaults: x ∈ [25, 614], y ∈ [25, 454].
  - Arithmetic is done in 11-bit signed, so there is no wrap at 0 or 1023.
  - Hitting a limit does not reset speed.
- **at_edge** is combinational from the registered positions: (x == min or x == max or y == min or y == max).
- **No ticks:** position and speed hold between ticks, whatever the button activity.
- **Reset values:**
  - `center_x` = START_X, `center_y` = START_Y.
  - Speeds 0, last dirs 0.
  - Debounced levels 0, debounce counters 0.
  - `screenEnd_d` = 1.
  - `at_edge` = 0 for default parameters.
- **Reset mid-motion:** reset takes precedence over a coincident tick.

## Timing
- `center_x` and `center_y` are registered. They change at the clock edge that ends the first cycle in which `screenEnd` is high, i.e. 1 cycle after the pulse rises, and are stable for the rest of the frame.
- Button-to-debounced latency is 2 + DEBOUNCE_CYCLES cycles. The first movement appears at the next tick after that.
- A tick in the same cycle the debounced level changes uses the old level.
- Only one update occurs per tick, even if `screenEnd` stays high for several cycles.

## Structure
- Shared package `box_game_pkg` holds:
  - SCREEN_W, SCREEN_H, HALF_SIZE.
  - The direction encoding (DIR_NEG, DIR_NONE, DIR_POS as 2-bit signed).
  - Clamp-limit localparams, reused by the VGA controller for its `within_box` bounds.
- Sub-module `button_debouncer` (synchroniser + counter, parameter DEBOUNCE_CYCLES) is instantiated four times.
- One shared axis-update function or task is used for both x and y.

## Test plan
Simulate with DEBOUNCE_CYCLES = 4 and ticks every 50 cycles.
1. **Reset:** hold `reset` = 0 for 3 cycles, release, give 5 ticks with no buttons → (320, 240) throughout, `at_edge` = 0.
2. **Speed ramp:** hold BTNR over 4 ticks → x = 321, 323, 326, 330. Continue 10 more ticks → step saturates at 8 per tick.
3. **Direction changes:**
   - Hold BTNR and BTNL together → x constant, speed → 0.
   - Release BTNL → next tick x += 1.
   - Swap to BTNL alone → next tick x −= 1.
4. **Clamp:**
   - Hold BTNR for 100 ticks → x reaches 614 and stays there, `at_edge` = 1.
   - Hold BTNU → y reaches 25, never below.
5. **Glitch rejection:** 3-cycle pulse on BTND → no y change over 5 ticks. An 8-cycle pulse before a tick → y = 241 on that tick.
6. **Reset mid-motion:**
   - Assert reset while x = 500 moving at speed 5 → (320, 240), speed 0.
   - Release reset with `screenEnd` held high → no update until the next rising edge.
